rvi_sft_issue: RTL
==================

RVI_SFT_ISSUE -- requirements
Module: rvi_sft_issue

Interface
REQ-001 SHALL have parameter RV64, default 0; 0 means RV32, 1 means RV64.
REQ-002 SHALL derive constant XLEN = 32*(RV64+1) and SW = 5+RV64 (shift-amount width).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 in_vld  in  1  instruction valid.
REQ-006 in_rdy  out  1  block can accept an instruction this cycle.
REQ-007 in_instr  in  32  RISC-V instruction word.
REQ-008 in_rs1  in  XLEN  rs1 operand value.
REQ-009 in_rs2  in  XLEN  rs2 operand value.
REQ-010 sft_op  out  3  shift-unit op: bit0 = left, bit1 = right, bit2 = arithmetic; bit2 is only ever set together with bit1.
REQ-011 sft_s1  out  XLEN  value to shift.
REQ-012 sft_s2  out  SW  shift amount.
REQ-013 sft_rslt  in  XLEN  combinational result from the shift execution unit.
REQ-014 out_vld / out_rdy  out / in  1 / 1  result handshake.
REQ-015 out_rd  out  5  destination register, instr[11:7].
REQ-016 out_data  out  XLEN  final result.
REQ-017 out_ill  out  1  instruction was not a legal shift.

Function
REQ-018 Decode SHALL accept opcodes OP (0110011) and OP-IMM (0010011), and for RV64 also OP-32 (0111011) and OP-IMM-32 (0011011).
REQ-019 funct3 = 001 with upper bits 0 SHALL decode to op 001 (SLL); funct3 = 101 with upper bits 0 to op 010 (SRL), with upper bits 0100000 (0x20 in funct7 / 0x10 in funct6) to op 110 (SRA).
REQ-020 Shift amount SHALL be rs2[SW-1:0] for register forms and instr[20+SW-1:20] for immediate forms; W forms use 5 bits.
REQ-021 RV32 SLLI/SRLI/SRAI with instr[25]=1, W-immediate forms with instr[25]=1, any other funct3/funct7, or other opcodes SHALL decode as illegal: out_ill=1, out_data=0, sft_op=000.
REQ-022 W forms: s1 = rs1[31:0] zero-extended for SRLW/SLLW and sign-extended for SRAW; out_data = sign-extension of sft_rslt[31:0] to 64 bits.
REQ-023 Pipeline SHALL be two stages: E register (drives sft_op/s1/s2 directly from flops) and W register (captures sft_rslt, rd, ill); latency is 2 cycles from accept to out_vld with out_rdy held high.
REQ-024 Accept SHALL occur when in_vld && in_rdy; in_rdy = !e_vld || (!w_vld || out_rdy).
REQ-025 E advances to W when e_vld && (!w_vld || out_rdy); W clears when out_vld && out_rdy and nothing advances into it.
REQ-026 Throughput SHALL be one instruction per cycle with out_rdy high; no instruction lost or duplicated under any out_rdy pattern.
REQ-027 out_rd/out_data/out_ill SHALL hold stable while out_vld && !out_rdy.
REQ-028 When E is empty, sft_op SHALL be 000 and sft_s1/sft_s2 SHALL be 0.
REQ-029 Simultaneous accept, E->W advance, and W drain in one cycle SHALL all take effect.

Reset
REQ-030 On rst: e_vld=0, w_vld=0, out_vld=0, out_data=0, out_rd=0, out_ill=0, sft_op=000, sft_s1=0, sft_s2=0; in_rdy=1 in the first cycle after rst deasserts.
REQ-031 rst asserted mid-operation SHALL discard all in-flight instructions; no output handshake completes for them.

Structure
REQ-032 Opcode/funct constants and the op encoding (L/R/A bit positions) SHALL live in the shared Rvi ISA package.
REQ-033 The decoder SHALL be one combinational sub-module rvi_sft_dec (instr, rs1, rs2 -> op, s1, s2, w_form, ill).

Verification
REQ-034 RV32, SRAI x, x, 4 with rs1=0x8000_0000 -> out_data=0xF800_0000, out_vld two cycles after accept.
REQ-035 RV32, SLL with rs1=0x0000_0001, rs2=0xFFFF_FFE3 -> sft_s2=3, out_data=0x0000_0008.
REQ-036 RV64, SRAIW with rs1=0x0000_0000_8000_0010, shamt 4 -> out_data=0xFFFF_FFFF_F800_0001.
REQ-037 RV32, SLLI with instr[25]=1 -> out_ill=1, out_data=0, sft_op=000.
REQ-038 Four back-to-back accepts with out_rdy low for 3 cycles -> in_rdy drops after 2 accepts, all four results emerge in order, values unchanged while stalled.
REQ-039 rst pulsed for one cycle with E and W both full -> out_vld=0 next cycle, no stale result later.

Source files
------------

// File: rtl/rvi_sft_issue_pkg.sv
// Shared RISC-V shift-issue definitions: opcode/funct encodings, shift-unit op
// encoding (left/right/arithmetic bit positions) and decode format tags.
package rvi_sft_issue_pkg;

  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;

  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SR  = 3'b101;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SRA  = 7'b0100000;
  localparam logic [5:0] F6_BASE = 6'b000000;
  localparam logic [5:0] F6_SRA  = 6'b010000;

  localparam int OP_L = 0;
  localparam int OP_R = 1;
  localparam int OP_A = 2;

  typedef logic [2:0] sft_op_t;

  localparam sft_op_t SFT_NONE = 3'b000;
  localparam sft_op_t SFT_SLL  = sft_op_t'(1 << OP_L);
  localparam sft_op_t SFT_SRL  = sft_op_t'(1 << OP_R);
  localparam sft_op_t SFT_SRA  = sft_op_t'((1 << OP_R) | (1 << OP_A));

  typedef enum logic [1:0] {
    FMT_REG,
    FMT_IMM,
    FMT_REGW,
    FMT_IMMW
  } sft_fmt_e;

  function automatic logic is_w_fmt(input sft_fmt_e f);
    return (f == FMT_REGW) || (f == FMT_IMMW);
  endfunction

endpackage

// File: rtl/rvi_sft_issue_if.sv
// Issue-side, shift-unit and result-side signals of the shift issue block.
interface rvi_sft_issue_if #(
  parameter int RV64 = 0
);
  localparam int XLEN = 32 * (RV64 + 1);
  localparam int SW   = 5 + RV64;

  logic            in_vld;
  logic            in_rdy;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_rs1;
  logic [XLEN-1:0] in_rs2;

  logic [2:0]      sft_op;
  logic [XLEN-1:0] sft_s1;
  logic [SW-1:0]   sft_s2;
  logic [XLEN-1:0] sft_rslt;

  logic            out_vld;
  logic            out_rdy;
  logic [4:0]      out_rd;
  logic [XLEN-1:0] out_data;
  logic            out_ill;

  modport slave (
    input  in_vld, in_instr, in_rs1, in_rs2, sft_rslt, out_rdy,
    output in_rdy, sft_op, sft_s1, sft_s2, out_vld, out_rd, out_data, out_ill
  );

  modport master (
    output in_vld, in_instr, in_rs1, in_rs2, sft_rslt, out_rdy,
    input  in_rdy, sft_op, sft_s1, sft_s2, out_vld, out_rd, out_data, out_ill
  );

endinterface

// File: rtl/rvi_sft_dec.sv
// Combinational shift decoder: recognises SLL/SRL/SRA in register, immediate
// and (RV64) word forms and prepares the shift-unit operands.
module rvi_sft_dec
  import rvi_sft_issue_pkg::*;
#(
  parameter  int RV64 = 0,
  localparam int XLEN = 32 * (RV64 + 1),
  localparam int SW   = 5 + RV64
) (
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output sft_op_t         op,
  output logic [XLEN-1:0] s1,
  output logic [SW-1:0]   s2,
  output logic            w_form,
  output logic            ill
);

  logic [6:0] opc;
  logic [6:0] f7;
  logic [5:0] f6;
  logic [2:0] f3;
  sft_fmt_e   fmt;
  logic       fmt_ok;
  logic       upper_base;
  logic       upper_alt;
  sft_op_t    dec;
  logic       unused_bits;

  assign opc = instr[6:0];
  assign f3  = instr[14:12];
  assign f7  = instr[31:25];
  assign f6  = instr[31:26];
  assign unused_bits = ^{instr[19:7], rs2};

  function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] v);
    logic signed [31:0] lo;
    lo = v[31:0];
    return XLEN'(lo);
  endfunction

  function automatic logic [XLEN-1:0] zext32(input logic [XLEN-1:0] v);
    return XLEN'(v[31:0]);
  endfunction

  always_comb begin
    fmt    = FMT_REG;
    fmt_ok = 1'b0;
    case (opc)
      OPC_OP:        begin fmt = FMT_REG;  fmt_ok = 1'b1;        end
      OPC_OP_IMM:    begin fmt = FMT_IMM;  fmt_ok = 1'b1;        end
      OPC_OP_32:     begin fmt = FMT_REGW; fmt_ok = (RV64 != 0); end
      OPC_OP_IMM_32: begin fmt = FMT_IMMW; fmt_ok = (RV64 != 0); end
      default: ;
    endcase

    // RV64 full-width immediates use instr[25] as shamt[5], so only funct6 qualifies them
    if (fmt == FMT_IMM && RV64 != 0) begin
      upper_base = (f6 == F6_BASE);
      upper_alt  = (f6 == F6_SRA);
    end else begin
      upper_base = (f7 == F7_BASE);
      upper_alt  = (f7 == F7_SRA);
    end

    dec = SFT_NONE;
    if (fmt_ok) begin
      if (f3 == F3_SLL && upper_base)     dec = SFT_SLL;
      else if (f3 == F3_SR && upper_base) dec = SFT_SRL;
      else if (f3 == F3_SR && upper_alt)  dec = SFT_SRA;
    end

    op     = SFT_NONE;
    s1     = '0;
    s2     = '0;
    w_form = 1'b0;
    ill    = 1'b1;
    if (dec != SFT_NONE) begin
      op     = dec;
      ill    = 1'b0;
      w_form = is_w_fmt(fmt);
      if (!w_form)         s1 = rs1;
      else if (dec[OP_A])  s1 = sext32(rs1);
      else                 s1 = zext32(rs1);
      case (fmt)
        FMT_REG:  s2 = rs2[SW-1:0];
        FMT_IMM:  s2 = instr[20+SW-1:20];
        FMT_REGW: s2 = SW'(rs2[4:0]);
        default:  s2 = SW'(instr[24:20]);
      endcase
    end
  end

endmodule

// File: rtl/rvi_sft_issue.sv
// Two-stage shift issue pipeline: E stage drives the external shift unit from
// flops, W stage captures its result and holds it for the output handshake.
module rvi_sft_issue
  import rvi_sft_issue_pkg::*;
#(
  parameter int RV64 = 0
) (
  input logic           clk,
  input logic           rst,
  rvi_sft_issue_if.slave bus
);

  localparam int XLEN = 32 * (RV64 + 1);
  localparam int SW   = 5 + RV64;

  sft_op_t         dec_op;
  logic [XLEN-1:0] dec_s1;
  logic [SW-1:0]   dec_s2;
  logic            dec_w;
  logic            dec_ill;

  logic            vld_p1;
  sft_op_t         op_p1;
  logic [XLEN-1:0] s1_p1;
  logic [SW-1:0]   s2_p1;
  logic [4:0]      rd_p1;
  logic            w_p1;
  logic            ill_p1;

  logic            vld_p2;
  logic [4:0]      rd_p2;
  logic [XLEN-1:0] data_p2;
  logic            ill_p2;

  logic            w_free;
  logic            adv;
  logic            in_rdy;
  logic            acc;
  logic [XLEN-1:0] rslt_fin;

  function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] v);
    logic signed [31:0] lo;
    lo = v[31:0];
    return XLEN'(lo);
  endfunction

  rvi_sft_dec #(.RV64(RV64)) u_dec (
    .instr  (bus.in_instr),
    .rs1    (bus.in_rs1),
    .rs2    (bus.in_rs2),
    .op     (dec_op),
    .s1     (dec_s1),
    .s2     (dec_s2),
    .w_form (dec_w),
    .ill    (dec_ill)
  );

  assign w_free = !vld_p2 || bus.out_rdy;
  assign adv    = vld_p1 && w_free;
  assign in_rdy = !vld_p1 || w_free;
  assign acc    = bus.in_vld && in_rdy;

  // ---- E stage: operands held in flops, zeroed whenever E empties
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      op_p1  <= SFT_NONE;
      s1_p1  <= '0;
      s2_p1  <= '0;
    end else if (acc) begin
      vld_p1 <= 1'b1;
      op_p1  <= dec_op;
      s1_p1  <= dec_s1;
      s2_p1  <= dec_s2;
    end else if (adv) begin
      vld_p1 <= 1'b0;
      op_p1  <= SFT_NONE;
      s1_p1  <= '0;
      s2_p1  <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (acc) begin
      rd_p1  <= bus.in_instr[11:7];
      w_p1   <= dec_w;
      ill_p1 <= dec_ill;
    end
  end

  assign rslt_fin = ill_p1 ? '0 : (w_p1 ? sext32(bus.sft_rslt) : bus.sft_rslt);

  // ---- W stage: captured result, held while the consumer stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2  <= 1'b0;
      rd_p2   <= '0;
      data_p2 <= '0;
      ill_p2  <= 1'b0;
    end else if (adv) begin
      vld_p2  <= 1'b1;
      rd_p2   <= rd_p1;
      data_p2 <= rslt_fin;
      ill_p2  <= ill_p1;
    end else if (bus.out_rdy) begin
      vld_p2  <= 1'b0;
    end
  end

  assign bus.in_rdy   = in_rdy;
  assign bus.sft_op   = op_p1;
  assign bus.sft_s1   = s1_p1;
  assign bus.sft_s2   = s2_p1;
  assign bus.out_vld  = vld_p2;
  assign bus.out_rd   = rd_p2;
  assign bus.out_data = data_p2;
  assign bus.out_ill  = ill_p2;

endmodule
